// File: rtl/dff_chk_pkg.sv
// Shared types and constants for the D flip-flop response checker.
//   chk_state_t   : control FSM states
//   chk_entry_t   : one slot of the capture/compare delay pipeline
//   CHK_DELAY_MAX : deepest supported capture-to-compare delay
//   clamp_delay() : folds an out-of-range delay parameter into 1..CHK_DELAY_MAX
package dff_chk_pkg;

  localparam int CHK_DELAY_MAX = 8;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StCheck,
    StFault
  } chk_state_t;

  typedef struct packed {
    logic valid;
    logic exp;
  } chk_entry_t;

  function automatic int clamp_delay(input int delay);
    if (delay < 1) begin
      return 1;
    end
    if (delay > CHK_DELAY_MAX) begin
      return CHK_DELAY_MAX;
    end
    return delay;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with +1 and +2 increments.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset (clears to 0)
//   inc_i  : add 1
//   inc2_i : add 2 (takes priority over inc_i)
//   cnt_o  : current count, holds at all-ones
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         inc2_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] CntMax = '1;

  logic [W-1:0] cnt_d, cnt_q;
  logic [W+1:0] step;
  logic [W+1:0] sum;

  always_comb begin
    step = '0;
    if (inc2_i) begin
      step = (W+2)'(2);
    end else if (inc_i) begin
      step = (W+2)'(1);
    end
    // Two guard bits so the overflow is visible before clamping.
    sum   = {2'b00, cnt_q} + step;
    cnt_d = (sum > {2'b00, CntMax}) ? CntMax : sum[W-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/dff_response_checker.sv
// Receive-side checker for a single-bit D flip-flop (cp/d in, q/qn out).
// Predicts the flop state on every detected cp rising edge, compares q a fixed
// number of clk cycles later, flags q changes outside any settling window and
// keeps saturating statistics.
//   clk, rst  : system clock, synchronous active-high reset
//   en        : arm; low clears pending compares and freezes statistics
//   cp, d     : strobe and data as driven to the flop
//   q, qn     : flop outputs under test
//   pass_cnt  : passed compares
//   err_cnt   : failed compares plus qn violations
//   spur_cnt  : q changes with nothing pending
//   err_flag  : sticky fault indicator (FSM in fault state)
//   exp_q     : most recently predicted flop state
//   busy      : at least one compare pending
module dff_response_checker
  import dff_chk_pkg::*;
#(
  parameter int unsigned CHECK_DELAY = 2,
  parameter int unsigned CNT_W       = 8,
  parameter bit          CHECK_QN    = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cp,
  input  logic             d,
  input  logic             q,
  input  logic             qn,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] spur_cnt,
  output logic             err_flag,
  output logic             exp_q,
  output logic             busy
);

  localparam int Depth = clamp_delay(int'(CHECK_DELAY));

  chk_entry_t pipe_q [Depth];
  chk_entry_t pipe_d [Depth];
  chk_entry_t tail;

  chk_state_t state_d, state_q;

  logic cp_q, q_q;
  logic exp_q_d, exp_q_q;
  logic busy_d, busy_q;

  logic cap;
  logic any_valid;
  logic tail_pass, tail_fail;
  logic qn_err, spur, fault_evt;
  logic err_inc, err_inc2;

  always_comb begin
    cap  = en & cp & ~cp_q;
    tail = pipe_q[Depth-1];

    any_valid = 1'b0;
    for (int i = 0; i < Depth; i++) begin
      any_valid = any_valid | pipe_q[i].valid;
    end

    tail_pass = en & tail.valid & (q == tail.exp);
    tail_fail = en & tail.valid & (q != tail.exp);
    qn_err    = CHECK_QN & en & (qn == q);
    // q may move freely while a capture is in flight or being taken.
    spur      = en & (q != q_q) & ~any_valid & ~cap;
    fault_evt = tail_fail | qn_err | spur;

    err_inc  = tail_fail ^ qn_err;
    err_inc2 = tail_fail & qn_err;

    pipe_d[0] = '{valid: cap, exp: d};
    for (int i = 1; i < Depth; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
    if (!en) begin
      for (int i = 0; i < Depth; i++) begin
        pipe_d[i].valid = 1'b0;
      end
    end

    busy_d = 1'b0;
    for (int i = 0; i < Depth; i++) begin
      busy_d = busy_d | pipe_d[i].valid;
    end

    exp_q_d = cap ? d : exp_q_q;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFault: state_d = StFault;
      StIdle, StArmed, StCheck: begin
        if (fault_evt) begin
          state_d = StFault;
        end else if (!en) begin
          state_d = StIdle;
        end else if (busy_d) begin
          state_d = StCheck;
        end else begin
          state_d = StArmed;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cp_q    <= 1'b0;
      q_q     <= 1'b0;
      exp_q_q <= 1'b0;
      busy_q  <= 1'b0;
      state_q <= StIdle;
      for (int i = 0; i < Depth; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      cp_q    <= cp;
      q_q     <= q;
      exp_q_q <= exp_q_d;
      busy_q  <= busy_d;
      state_q <= state_d;
      for (int i = 0; i < Depth; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_pass_cnt (
    .clk_i  (clk),
    .rst_i  (rst),
    .inc_i  (tail_pass),
    .inc2_i (1'b0),
    .cnt_o  (pass_cnt)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_err_cnt (
    .clk_i  (clk),
    .rst_i  (rst),
    .inc_i  (err_inc),
    .inc2_i (err_inc2),
    .cnt_o  (err_cnt)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_spur_cnt (
    .clk_i  (clk),
    .rst_i  (rst),
    .inc_i  (spur),
    .inc2_i (1'b0),
    .cnt_o  (spur_cnt)
  );

  // The fault state is sticky until reset, so it doubles as the error flag.
  assign err_flag = (state_q == StFault);
  assign exp_q    = exp_q_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_dff_response_checker.sv
// Bench for dff_response_checker: three instances (default, qn rule off,
// 2-bit counters) share stimulus; a due-time queue model predicts every output.
module tb_dff_response_checker;

  localparam int Delay = 2;

  logic clk = 1'b0;
  logic rst, en, cp, d, q, qn;

  logic [7:0] pass0, err0, spur0;
  logic [7:0] pass1, err1, spur1;
  logic [1:0] pass2, err2, spur2;
  logic flag0, flag1, flag2, expq0, expq1, expq2, busy0, busy1, busy2;

  always #5 clk = ~clk;

  dff_response_checker #(.CHECK_DELAY(Delay), .CNT_W(8), .CHECK_QN(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en), .cp(cp), .d(d), .q(q), .qn(qn),
    .pass_cnt(pass0), .err_cnt(err0), .spur_cnt(spur0),
    .err_flag(flag0), .exp_q(expq0), .busy(busy0)
  );

  dff_response_checker #(.CHECK_DELAY(Delay), .CNT_W(8), .CHECK_QN(1'b0)) dut_nq (
    .clk(clk), .rst(rst), .en(en), .cp(cp), .d(d), .q(q), .qn(qn),
    .pass_cnt(pass1), .err_cnt(err1), .spur_cnt(spur1),
    .err_flag(flag1), .exp_q(expq1), .busy(busy1)
  );

  dff_response_checker #(.CHECK_DELAY(Delay), .CNT_W(2), .CHECK_QN(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .cp(cp), .d(d), .q(q), .qn(qn),
    .pass_cnt(pass2), .err_cnt(err2), .spur_cnt(spur2),
    .err_flag(flag2), .exp_q(expq2), .busy(busy2)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int due;
    bit exp;
  } pend_t;

  pend_t pq[$];
  int    cyc = 0;
  int    m_pass[3], m_err[3], m_spur[3];
  bit    m_flag[3];
  bit    m_exp, m_busy, m_cp, m_q;
  int    cnt_max[3] = '{255, 255, 3};
  bit    qn_on[3]   = '{1'b1, 1'b0, 1'b1};

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  always @(posedge clk) begin
    bit   cap, pending, passed, failed, spur, qerr;
    int   nerr;
    pend_t e;
    cyc++;
    if (rst) begin
      pq.delete();
      for (int k = 0; k < 3; k++) begin
        m_pass[k] = 0; m_err[k] = 0; m_spur[k] = 0; m_flag[k] = 0;
      end
      m_exp = 0; m_cp = 0; m_q = 0;
    end else begin
      cap     = en && cp && !m_cp;
      pending = (pq.size() != 0);
      passed  = 0;
      failed  = 0;
      if (en) begin
        while (pq.size() != 0 && pq[0].due == cyc) begin
          e = pq.pop_front();
          if (q == e.exp) passed = 1; else failed = 1;
        end
        spur = (q != m_q) && !pending && !cap;
        for (int k = 0; k < 3; k++) begin
          qerr = qn_on[k] && (qn == q);
          nerr = int'(failed) + int'(qerr);
          m_err[k]  = sat(m_err[k] + nerr, cnt_max[k]);
          m_pass[k] = sat(m_pass[k] + int'(passed), cnt_max[k]);
          m_spur[k] = sat(m_spur[k] + int'(spur), cnt_max[k]);
          if (failed || qerr || spur) m_flag[k] = 1;
        end
        if (cap) begin
          pq.push_back('{due: cyc + Delay, exp: d});
          m_exp = d;
        end
      end else begin
        pq.delete();
      end
      m_cp = cp;
      m_q  = q;
    end
    m_busy = (pq.size() != 0);
  end

  // Per-cycle comparison of all three instances against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("pass0", 32'(pass0), m_pass[0]); check("err0", 32'(err0), m_err[0]);
      check("spur0", 32'(spur0), m_spur[0]); check("flag0", 32'(flag0), 32'(m_flag[0]));
      check("expq0", 32'(expq0), 32'(m_exp)); check("busy0", 32'(busy0), 32'(m_busy));
      check("pass1", 32'(pass1), m_pass[1]); check("err1", 32'(err1), m_err[1]);
      check("spur1", 32'(spur1), m_spur[1]); check("flag1", 32'(flag1), 32'(m_flag[1]));
      check("pass2", 32'(pass2), m_pass[2]); check("err2", 32'(err2), m_err[2]);
      check("spur2", 32'(spur2), m_spur[2]); check("flag2", 32'(flag2), 32'(m_flag[2]));
      check("busy2", 32'(busy2), 32'(m_busy));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; en = 0; cp = 0; d = 0; q = 0; qn = 1;
    tick(1);
    rst = 0; en = 1;
  endtask

  // One cp pulse; the emulated flop follows d when follow is set.
  task automatic pulse(input logic dv, input bit follow);
    cp = 1; d = dv;
    if (follow) begin
      q = dv; qn = ~dv;
    end
    tick(1);
    cp = 0;
    tick(3);
  endtask

  initial begin
    rst = 1; en = 0; cp = 0; d = 0; q = 0; qn = 1;
    tick(2);
    chk_on = 1;
    settle();
    check("rst_pass", 32'(pass0), 0); check("rst_err", 32'(err0), 0);
    check("rst_flag", 32'(flag0), 0); check("rst_busy", 32'(busy0), 0);

    // Normal operation with a correctly following flop.
    do_reset();
    cp = 1; d = 0; tick(1);
    settle();
    check("cap_busy", 32'(busy0), 1);
    cp = 0; tick(3);
    pulse(1'b1, 1'b1);
    tick(1); settle();
    check("norm_pass", 32'(pass0), 2); check("norm_err", 32'(err0), 0);
    check("norm_spur", 32'(spur0), 0); check("norm_flag", 32'(flag0), 0);
    check("norm_expq", 32'(expq0), 1);

    // q stuck at 0.
    do_reset();
    pulse(1'b0, 1'b0);
    pulse(1'b1, 1'b0);
    tick(1); settle();
    check("stuck_pass", 32'(pass0), 1); check("stuck_err", 32'(err0), 1);
    check("stuck_flag", 32'(flag0), 1);

    // Spurious q toggles with no cp activity.
    do_reset();
    q = 1; qn = 0; tick(3);
    q = 0; qn = 1; tick(3);
    settle();
    check("spur_spur", 32'(spur0), 2); check("spur_flag", 32'(flag0), 1);
    check("spur_pass", 32'(pass0), 0);

    // qn equal to q for three cycles.
    do_reset();
    qn = 0; tick(3);
    qn = 1; tick(2);
    settle();
    check("qn_err", 32'(err0), 3); check("qn_flag", 32'(flag0), 1);
    check("qnoff_err", 32'(err1), 0); check("qnoff_flag", 32'(flag1), 0);

    // cp held high: exactly one capture and compare.
    do_reset();
    cp = 1; d = 1; q = 1; qn = 0; tick(5);
    cp = 0; tick(3);
    settle();
    check("hold_pass", 32'(pass0), 1); check("hold_err", 32'(err0), 0);
    check("hold_spur", 32'(spur0), 0);

    // Reset one cycle after a capture that would otherwise fail.
    do_reset();
    cp = 1; d = 1; tick(1);
    cp = 0; rst = 1; tick(1);
    rst = 0; tick(4);
    settle();
    check("rstmid_busy", 32'(busy0), 0); check("rstmid_pass", 32'(pass0), 0);
    check("rstmid_err", 32'(err0), 0); check("rstmid_flag", 32'(flag0), 0);
    check("rstmid_expq", 32'(expq0), 0);

    // en dropped while a failing compare is pending; q moves while disarmed.
    do_reset();
    cp = 1; d = 1; tick(1);
    cp = 0; en = 0; q = 1; qn = 0; tick(4);
    en = 1; tick(3);
    settle();
    check("en_err", 32'(err0), 0); check("en_spur", 32'(spur0), 0);
    check("en_busy", 32'(busy0), 0); check("en_expq", 32'(expq0), 1);

    // Saturation: five failing compares on 2-bit counters.
    do_reset();
    repeat (5) pulse(1'b1, 1'b0);
    tick(2); settle();
    check("sat_err2", 32'(err2), 3); check("sat_err0", 32'(err0), 5);
    check("sat_flag2", 32'(flag2), 1); check("sat_pass2", 32'(pass2), 0);

    chk_on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
